// File: rtl/fuzzy_pkg.sv
// Shared fuzzy-logic types: default operand width, controller states and the
// bitwise cut-line combine used by both the datapath and its reference model.
package fuzzy_pkg;

   localparam int WIDTH_DEFAULT = 10;

   typedef bit [WIDTH_DEFAULT-1:0] LongBitSum;

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      DONE
   } state_t;

   // Per bit: cut 0 selects min (AND), cut 1 selects max (OR).
   function automatic LongBitSum fuzzy_cut_combine(input LongBitSum cut,
                                                   input LongBitSum a,
                                                   input LongBitSum b);
      return (~cut & (a & b)) | (cut & (a | b));
   endfunction

endpackage

// File: rtl/cut_combine_unit.sv
// Combinational per-bit cut-line combiner: z = min(x,y) where cut=0,
// max(x,y) where cut=1. Purely bitwise, no carries.
module cut_combine_unit #(
   parameter int WIDTH = 10
) (
   input  logic [WIDTH-1:0] cut,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] z
);

   assign z = (~cut & (x & y)) | (cut & (x | y));

endmodule

// File: rtl/cut_line_fold_ctl.sv
// Folds a valid/ready stream of fuzzy operands into one accumulator per rule
// and hands the result, operand count and overflow flag downstream.
module cut_line_fold_ctl #(
   parameter int WIDTH   = fuzzy_pkg::WIDTH_DEFAULT,
   parameter int MAX_OPS = 16,
   localparam int CNT_W  = $clog2(MAX_OPS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [WIDTH-1:0] cfg_cut,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_x,
   input  logic [WIDTH-1:0] in_cut,
   input  logic             in_use_cfg,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_z,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf,
   output logic             busy
);
   import fuzzy_pkg::*;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OPS);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] acc, acc_nxt;
   logic [WIDTH-1:0] cut_reg, cut_eff, comb_z;
   logic [CNT_W-1:0] count, count_nxt;
   logic             ovf, ovf_nxt;
   logic             beat, take, first_beat;

   // in_ready is forced high while rst is held so upstream never sees a stall
   // from a DONE state that is about to be cleared.
   assign in_ready   = rst | (state != DONE) | out_ready;
   assign out_valid  = (state == DONE);
   assign busy       = (state != IDLE);
   assign beat       = in_valid & in_ready;
   assign take       = out_valid & out_ready;
   assign first_beat = beat & ((state == IDLE) | ((state == DONE) & take));
   assign cut_eff    = in_use_cfg ? cut_reg : in_cut;

   assign out_z      = acc;
   assign out_count  = count;
   assign out_ovf    = ovf;

   cut_combine_unit #(.WIDTH(WIDTH)) u_combine (
      .cut (cut_eff),
      .x   (acc),
      .y   (in_x),
      .z   (comb_z)
   );

   // NOTE: every next-state signal gets its hold value first, so no path
   // through this block leaves one unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      count_nxt = count;
      ovf_nxt   = ovf;
      if (first_beat) begin
         acc_nxt   = in_x;
         count_nxt = CNT_ONE;
         ovf_nxt   = 1'b0;
         state_nxt = in_last ? DONE : ACC;
      end else if ((state == ACC) && beat) begin
         acc_nxt = comb_z;
         if (count == CNT_MAX) begin
            ovf_nxt = 1'b1;
         end else begin
            count_nxt = count + CNT_ONE;
         end
         state_nxt = in_last ? DONE : ACC;
      end else if ((state == DONE) && take) begin
         state_nxt = IDLE;
      end
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         acc   <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         count <= count_nxt;
         ovf   <= ovf_nxt;
      end
   end

   // A beat in the same cycle as a write still sees the old cut_reg.
   always_ff @(posedge clk) begin
      if (rst) begin
         cut_reg <= '0;
      end else if (cfg_we) begin
         cut_reg <= cfg_cut;
      end
   end

endmodule

// File: tb/tb_cut_line_fold_ctl.sv
// Scoreboard bench for cut_line_fold_ctl: a rule-level reference model queues
// expected results as beats are accepted; a monitor pops them on each handshake.
module tb_cut_line_fold_ctl;
   import fuzzy_pkg::*;

   localparam int W     = 10;
   localparam int MAXOP = 16;
   localparam int CW    = $clog2(MAXOP + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cfg_we = 1'b0;
   logic [W-1:0]  cfg_cut = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_x = '0;
   logic [W-1:0]  in_cut = '0;
   logic          in_use_cfg = 1'b0;
   logic          in_last = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_z;
   logic [CW-1:0] out_count;
   logic          out_ovf;
   logic          busy;

   cut_line_fold_ctl #(.WIDTH(W), .MAX_OPS(MAXOP)) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_we     (cfg_we),
      .cfg_cut    (cfg_cut),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_x       (in_x),
      .in_cut     (in_cut),
      .in_use_cfg (in_use_cfg),
      .in_last    (in_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_z      (out_z),
      .out_count  (out_count),
      .out_ovf    (out_ovf),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (rule level) ----------------
   typedef struct {
      logic [W-1:0]  z;
      logic [CW-1:0] cnt;
      logic          ovf;
   } exp_t;

   exp_t      exp_q[$];
   LongBitSum op_x[$];
   LongBitSum op_cut[$];
   LongBitSum m_cut_reg = '0;

   task automatic model_beat(input LongBitSum x, input LongBitSum cut,
                             input bit use_cfg, input bit last);
      exp_t      e;
      LongBitSum z;
      int        n;
      op_x.push_back(x);
      op_cut.push_back(use_cfg ? m_cut_reg : cut);
      if (last) begin
         z = op_x[0];
         for (int i = 1; i < op_x.size(); i++) z = fuzzy_cut_combine(op_cut[i], z, op_x[i]);
         n     = op_x.size();
         e.z   = z;
         e.cnt = CW'((n > MAXOP) ? MAXOP : n);
         e.ovf = (n > MAXOP);
         exp_q.push_back(e);
         op_x.delete();
         op_cut.delete();
      end
   endtask

   // ---------------- monitor ----------------
   // ready_mode: 0 random, 1 hold low, 2 hold high
   int ready_mode = 2;

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         case (ready_mode)
            1:       out_ready = 1'b0;
            2:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 9) < 7);
         endcase
         #1;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected result", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("out_z", 32'(out_z), 32'(e.z));
               check("out_count", 32'(out_count), 32'(e.cnt));
               check("out_ovf", 32'(out_ovf), 32'(e.ovf));
            end
         end
      end
   end

   // ---------------- driver ----------------
   // Called right after a negedge; returns right after the negedge following acceptance.
   task automatic send(input LongBitSum x, input LongBitSum cut, input bit use_cfg,
                       input bit last, input bit we, input LongBitSum wcut);
      bit acc;
      in_valid   = 1'b1;
      in_x       = x;
      in_cut     = cut;
      in_use_cfg = use_cfg;
      in_last    = last;
      cfg_we     = we;
      cfg_cut    = wcut;
      for (int t = 0; t < 200; t++) begin
         #2;
         acc = in_ready;
         if (acc) model_beat(x, cut, use_cfg, last);
         if (cfg_we) m_cut_reg = cfg_cut;
         @(negedge clk);
         cfg_we = 1'b0;
         if (acc) break;
         if (t == 199) check("in_ready timeout", 32'd0, 32'd1);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drain();
      for (int t = 0; t < 400 && exp_q.size() != 0; t++) @(negedge clk);
      check("scoreboard drained", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      @(negedge clk);
      #2;
      check("in_ready during reset", 32'(in_ready), 32'd1);
      tick(2);
      rst = 1'b0;
      #2;
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset out_z", 32'(out_z), 32'd0);
      check("reset out_count", 32'(out_count), 32'd0);
      check("reset out_ovf", 32'(out_ovf), 32'd0);
      check("reset in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);

      // Single beat
      send(10'h2A5, 10'h000, 0, 1, 0, 0);
      // Three beats
      send(10'h3F0, 10'h000, 0, 0, 0, 0);
      send(10'h0FF, 10'h000, 0, 0, 0, 0);
      send(10'h30A, 10'h3FF, 0, 1, 0, 0);
      // Mixed cut
      send(10'h3F0, 10'h000, 0, 0, 0, 0);
      send(10'h00F, 10'h3C0, 0, 1, 0, 0);
      // Config timing: write in the same cycle as beat 2 (old cut 0 -> AND)
      send(10'h0F0, 10'h000, 0, 0, 0, 0);
      send(10'h00F, 10'h000, 1, 0, 1, 10'h3FF);
      send(10'h005, 10'h000, 1, 1, 0, 0);
      drain();

      // Backpressure, then back-to-back start in the release cycle
      ready_mode = 1;
      send(10'h2A5, 10'h000, 0, 1, 0, 0);
      repeat (3) begin
         #2;
         check("held out_valid", 32'(out_valid), 32'd1);
         check("held out_z", 32'(out_z), 32'h2A5);
         check("held out_count", 32'(out_count), 32'd1);
         check("held in_ready", 32'(in_ready), 32'd0);
         @(negedge clk);
      end
      ready_mode = 2;
      send(10'h111, 10'h000, 0, 1, 0, 0);
      #2;
      check("b2b out_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
      drain();

      // Overflow: 18 beats of all-ones
      for (int i = 0; i < 18; i++) send(10'h3FF, 10'($urandom), 0, (i == 17), 0, 0);
      drain();

      // Reset mid-rule
      send(10'h155, 10'h000, 0, 0, 0, 0);
      send(10'h0AA, 10'h3FF, 0, 0, 0, 0);
      rst = 1'b1;
      #2;
      check("in_ready in mid-rule reset", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      m_cut_reg = '0;
      op_x.delete();
      op_cut.delete();
      #2;
      check("post-reset busy", 32'(busy), 32'd0);
      check("post-reset out_valid", 32'(out_valid), 32'd0);
      check("post-reset out_count", 32'(out_count), 32'd0);
      @(negedge clk);
      send(10'h001, 10'h000, 0, 1, 0, 0);
      drain();

      // Randomised rules with random backpressure, cut writes and gaps
      ready_mode = 0;
      for (int r = 0; r < 60; r++) begin
         int len;
         len = ($urandom_range(0, 7) == 0) ? $urandom_range(15, 20) : $urandom_range(1, 5);
         for (int b = 0; b < len; b++) begin
            send(10'($urandom), 10'($urandom), 1'($urandom), (b == len - 1),
                 ($urandom_range(0, 5) == 0), 10'($urandom));
            if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 2));
         end
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cut_line_fold_ctl.md
Name: cut_line_fold_ctl

Overview:
- Sequencing controller for the per-bit fuzzy cut-line combiner.
- Accepts a stream of fuzzy operands through a valid/ready handshake and folds them into one accumulator, one operand per cycle.
- Each step uses the combine rule acc = (~cut & (acc & x)) | (cut & (acc | x)).
  - cut bit 0 gives min/AND.
  - cut bit 1 gives max/OR.
- Emits one result per rule (operands up to and including in_last), with an operand count and an overflow flag, to downstream defuzzification logic.

Parameters:
- WIDTH, 10: fuzzy-number bit width (same as the LongBitSum width).
- MAX_OPS, 16: maximum operands counted per rule.
- CNT_W, $clog2(MAX_OPS+1): operand-count width (derived, not overridden).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  write strobe for the programmed cut register.
- cfg_cut  in  WIDTH  value written to the cut register.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  controller can accept a beat.
- in_x  in  WIDTH  operand.
- in_cut  in  WIDTH  per-beat cut line.
- in_use_cfg  in  1  1 = use the programmed cut register instead of in_cut.
- in_last  in  1  marks the final operand of a rule.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_z  out  WIDTH  folded result.
- out_count  out  CNT_W  operands counted (saturating).
- out_ovf  out  1  rule exceeded MAX_OPS operands.
- busy  out  1  state != IDLE.

Behaviour:
- Beat accepted = in_valid & in_ready.
- Result accepted = out_valid & out_ready.
- States:
  - IDLE: accumulator empty.
  - ACC: partial rule held.
  - DONE: result presented.
- in_ready = (state != DONE) | out_ready. This allows a back-to-back rule start in the same cycle the result is taken.
- Effective cut: cut_eff = in_use_cfg ? cut_reg : in_cut.
- First beat of a rule, accepted in IDLE, or in DONE together with result acceptance:
  - acc <= in_x, count <= 1, ovf <= 0; cut_eff is ignored.
  - Next state is DONE if in_last, else ACC.
- Beat accepted in ACC:
  - acc <= combine(cut_eff, acc, in_x).
  - If count == MAX_OPS: count holds and ovf <= 1 (sticky for this rule). Otherwise count <= count+1.
  - The operand is still combined after overflow.
  - Next state is DONE if in_last, else ACC.
- ACC with no beat: hold everything. There is no timeout.
- DONE:
  - out_valid = 1; out_z = acc, out_count = count, out_ovf = ovf.
  - Outputs stay stable until the result is accepted.
  - Result accepted with no beat: go to IDLE.
  - Result accepted with a beat: apply the first-beat rule above; no bubble and no lost beat.
- Latency: result is valid the cycle after the last beat is accepted. Minimum throughput is one N-operand rule per N cycles.
- Cut register:
  - On cfg_we, cut_reg <= cfg_cut, visible from the next cycle.
  - A beat in the same cycle as cfg_we uses the old value.
  - Writes are allowed in any state.
- Reset (any state, including mid-rule): state IDLE, acc 0, count 0, ovf 0, cut_reg 0, out_valid 0, busy 0, out_z 0, out_count 0, out_ovf 0. Any partial rule is discarded.
  - in_ready is 1 during and after reset.
- Arithmetic: the combine is purely bitwise with no carries. out_count saturates at MAX_OPS.

Decomposition:
- Package fuzzy_pkg holds:
  - WIDTH default, typedef LongBitSum (bit [WIDTH-1:0]);
  - state enum {IDLE, ACC, DONE};
  - function fuzzy_cut_combine(cut, a, b), shared with the bench's reference model.
- Sub-module cut_combine_unit: combinational per-bit cut combiner (cut, x, y -> z), instantiated once on the acc/in_x path.
- The FSM, counter and registers stay in cut_line_fold_ctl.

Test Plan:
- Single beat: x=0x2A5, last=1 -> next cycle out_valid=1, z=0x2A5, count=1, ovf=0.
- Three beats:
  - x=0x3F0; then x=0x0FF with cut=0x000; then x=0x30A with cut=0x3FF, last=1.
  - -> z=0x3FA (0x3F0 & 0x0FF = 0x0F0, then OR 0x30A), count=3.
- Mixed cut: x=0x3F0; then x=0x00F with cut=0x3C0, last=1 -> z=0x3C0.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 3 cycles -> z/count stable, in_ready=0.
  - Then raise out_ready with in_valid=1, x=0x111, last=1 in the same cycle -> next cycle z=0x111, count=1; no beat dropped.
- Config timing:
  - cfg_we=1, cfg_cut=0x3FF in the same cycle as beat 2 (in_use_cfg=1) on acc 0x0F0 with x=0x00F -> AND result 0x000.
  - Beat 3 with x=0x005, in_use_cfg=1, last=1 -> OR gives z=0x005.
- Overflow and reset:
  - 18 beats of 0x3FF, last on 18th -> count=16, ovf=1, z=0x3FF.
  - Separately, rst after 2 beats of a rule -> busy=0, out_valid=0. The next single-beat rule x=0x001 yields z=0x001, count=1.
